// File: rtl/serial_tx_sched_pkg.sv
// Shared types and constants for the serial transmit scheduler.
package serial_pkg;

    localparam int unsigned MIN_WIDTH = 2;

    // Scheduler phases: waiting for a word, shifting a frame, idle gap.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Requester index (0 or 1).
    typedef logic req_id_t;

    // Counter width able to hold n-1 down to 0; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_sched_if.sv
// Requester handshakes and serial-side status of the transmit scheduler.
interface serial_tx_sched_if #(
    parameter int unsigned WIDTH = 8
);
    import serial_pkg::*;

    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             sout;
    logic             frame;
    logic             done;
    logic             busy;
    req_id_t          grant_id;

    // Producer / observer side.
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, sout, frame, done, busy, grant_id
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, sout, frame, done, busy, grant_id
    );

endinterface

// File: rtl/serial_tx_sched_piso.sv
// Parallel-in / serial-out shift register, MSB first; load wins over shift.
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Next register contents: parallel load, left shift with zero fill, or hold.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sout = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_tx_sched.sv
// Two-requester round-robin transmit scheduler driving one MSB-first serial line.
module serial_tx_sched
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    serial_tx_sched_if.slave bus
);

    localparam int unsigned CNT_W  = cnt_width(WIDTH);
    localparam int unsigned GCNT_W = cnt_width(GAP + 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [GCNT_W-1:0] gap_cnt_q;
    logic [GCNT_W-1:0] gap_cnt_d;
    req_id_t           last_grant_q;
    req_id_t           last_grant_d;
    req_id_t           grant_id_q;
    req_id_t           grant_id_d;

    logic             grant0;
    logic             grant1;
    logic             xfer0;
    logic             xfer1;
    logic             xfer;
    logic             shift_en;
    logic             shift_out;
    logic [WIDTH-1:0] load_data;

    // Round-robin arbitration: under contention the requester not granted last wins.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || (last_grant_q == 1'b1));
        grant1 = bus.req1_valid && (!bus.req0_valid || (last_grant_q == 1'b0));
    end

    assign bus.req0_ready = (state_q == ST_IDLE) && grant0 && !reset;
    assign bus.req1_ready = (state_q == ST_IDLE) && grant1 && !reset;

    // Handshake completion and word selection for the shift register.
    always_comb begin
        xfer0     = bus.req0_valid && bus.req0_ready;
        xfer1     = bus.req1_valid && bus.req1_ready;
        xfer      = xfer0 || xfer1;
        load_data = xfer1 ? bus.req1_data : bus.req0_data;
        shift_en  = (state_q == ST_SHIFT);
    end

    // Next-state logic: accept in IDLE, count frame bits, then count gap cycles.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d      = ST_SHIFT;
                    bit_cnt_d    = CNT_W'(WIDTH - 1);
                    last_grant_d = xfer1;
                    grant_id_d   = xfer1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GCNT_W'(GAP - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counters; reset aborts any frame and re-arms req0 for first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (xfer),
        .shift (shift_en),
        .din   (load_data),
        .sout  (shift_out)
    );

    // Serial-side status decoded purely from registered state.
    assign bus.frame    = (state_q == ST_SHIFT);
    assign bus.done     = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.sout     = shift_out && (state_q == ST_SHIFT);
    assign bus.grant_id = grant_id_q;

endmodule

// File: doc/serial_tx_sched.md
# serial_tx_sched

Transmit scheduler for the serial shift-register path. It arbitrates between two parallel-word requesters using round-robin, loads the granted word into a parallel-in/serial-out shift register, and sequences a WIDTH-bit MSB-first serial frame. It then inserts a programmable idle gap before accepting the next word. It sits between the parallel producers and the single serial output line.

## Interface
Parameters:
- WIDTH, default 8: bits per word; minimum 2.
- GAP, default 1: idle cycles after each frame; 0 is allowed.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- req0_valid, in, 1: requester 0 has a word.
- req0_data, in, WIDTH: requester 0 word.
- req0_ready, out, 1: requester 0 word accepted this cycle when high together with valid.
- req1_valid, in, 1: requester 1 has a word.
- req1_data, in, WIDTH: requester 1 word.
- req1_ready, out, 1: requester 1 accept.
- sout, out, 1: serial data, MSB first; 0 outside a frame.
- frame, out, 1: high for exactly the WIDTH cycles carrying frame bits.
- done, out, 1: one-cycle pulse during the last bit of a frame.
- busy, out, 1: high in the SHIFT and GAP states.
- grant_id, out, 1: source of the current or most recent frame.

## Operation
- States:
  - IDLE: accept allowed.
  - SHIFT: WIDTH bit cycles.
  - GAP: GAP cycles.
  - Reset state is IDLE.
- Arbitration happens in IDLE only, combinationally from the valids and the last_grant register.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted.
  - last_grant resets to 1, so requester 0 wins the first contention.
- reqN_ready = (state == IDLE) && grantN && !reset. Ready may depend on valid. Valid must not depend on ready.
- Transfer occurs when valid && ready. At that edge:
  - the data is loaded into the shift register;
  - grant_id and last_grant are updated;
  - the bit counter is set to WIDTH-1;
  - the state moves to SHIFT.
- SHIFT:
  - sout = shift register MSB; frame = 1.
  - Each edge shifts left by one and decrements the counter.
  - When the counter is 0, done = 1 in that cycle.
  - At the following edge the state moves to GAP if GAP > 0, else to IDLE.
- GAP: the gap counter runs GAP-1 down to 0, then the state moves to IDLE. sout and frame are 0.
- Deasserting valid before the transfer is legal; nothing happens. Data is sampled only at the transfer edge; later changes are ignored.
- Counter widths are $clog2(WIDTH) and $clog2(GAP+1) (minimum 1). No arithmetic beyond these decrements.
- Reset mid-frame aborts the frame immediately (asynchronous):
  - sout, frame, done and busy go to 0;
  - no done pulse is produced;
  - the state returns to IDLE and last_grant to 1.
- Reset values: sout 0, frame 0, done 0, busy 0, grant_id 0, req0_ready 0, req1_ready 0. The shift register and all counters are cleared to 0.

## Timing
- Transfer at edge E ends cycle T. Bit k (MSB = k0) is driven during cycle T+1+k, for k = 0..WIDTH-1.
- done is high in cycle T+WIDTH.
- busy is high from T+1 through T+WIDTH+GAP.
- The earliest next ready is cycle T+WIDTH+GAP+1.
- Back-to-back period is WIDTH+GAP+1 cycles per word. This is 10 cycles at the defaults.
- Outputs sout, frame, done, busy and grant_id are registered or decoded from registered state only, with no input-to-output combinational path. The readies are the exception (combinational from valids).

## Structure
- Package serial_pkg:
  - state enum typedef (IDLE, SHIFT, GAP);
  - requester-id typedef;
  - MIN_WIDTH constant (2).
- Sub-module piso_shift, parameter WIDTH:
  - ports: clk, reset, load, shift, din[WIDTH], sout;
  - priority: load over shift;
  - asynchronous active-high clear.
- Top level contains the arbiter, FSM and counters, and instantiates piso_shift.

## Test plan
- Single word: req0 sends 8'hA5 at cycle T. Required: sout = 1,0,1,0,0,1,0,1 over T+1..T+8, frame high for exactly those 8 cycles, done only at T+8, grant_id 0, req0_ready high only in T.
- Contention: both valid continuously, req0 = 8'h0F, req1 = 8'hF0. Required: grants alternate 0,1,0,1; frames start every 10 cycles; grant_id alternates accordingly.
- Single requester streaming: req1 always valid. Required: every word is accepted, accepts are 10 cycles apart, and sout is 0 during each GAP cycle.
- Reset mid-frame: assert reset during bit 3 of 8'hFF. Required: sout, frame and busy go to 0 immediately, no done pulse. After release, the first contention goes to req0.
- GAP = 0 build, WIDTH = 4: req0 streams 4'h9. Required: period 5 cycles, sout = 1,0,0,1, then one IDLE cycle at 0.
- Valid withdrawn: req0_valid pulses low in IDLE before any edge with ready. Required: no transfer, and all outputs stay at reset values.
